alu_seq: RTL and testbench

//  Parametrised, registered ALU with valid/ready handshakes for the multi-cycle MIPS datapath.

---
 rtl/alu_seq_if.sv | 30 +++
 rtl/alu_seq.sv | 179 +++++++++++++++++
 tb/tb_alu_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle for alu_seq.
// The producer/consumer side uses the master modport, and the ALU uses the slave modport.
interface alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alucontrol;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] aluout;
  logic [WIDTH-1:0] aluout_hi;
  logic             zero;
  logic             SF;
  logic             ovf;

  modport master (
    output in_valid, a, b, alucontrol, shamt, out_ready,
    input  in_ready, out_valid, aluout, aluout_hi, zero, SF, ovf
  );

  modport slave (
    input  in_valid, a, b, alucontrol, shamt, out_ready,
    output in_ready, out_valid, aluout, aluout_hi, zero, SF, ovf
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes. Fast ops finish in one cycle.
// MULU (shift-add) and DIVU (restoring) each iterate one bit per cycle for WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010, OP_XOR  = 4'b0011,
    OP_ANDN = 4'b0100, OP_ORN  = 4'b0101, OP_SUB  = 4'b0110, OP_SLTU = 4'b0111,
    OP_NOR  = 4'b1000, OP_MULU = 4'b1001, OP_SLL  = 4'b1010, OP_SRA  = 4'b1011,
    OP_SRL  = 4'b1100, OP_SLT  = 4'b1101, OP_DIVU = 4'b1110, OP_RSVD = 4'b1111
  } op_e;

  localparam int unsigned MSB = WIDTH - 1;
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] aluout_q, aluout_d;
  logic [WIDTH-1:0] aluout_hi_q, aluout_hi_d;
  logic             zero_q, zero_d;
  logic             sf_q, sf_d;
  logic             ovf_q, ovf_d;

  op_e              op;
  logic [WIDTH-1:0] sum, diff, fast_res;
  logic             fast_ovf;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign op = op_e'(bus.alucontrol);

  // Fast ops evaluate straight from the bus on the accept edge and register into the result.
  // This is equivalent to latching the operands first.
  always_comb begin
    sum      = bus.a + bus.b;
    diff     = bus.a - bus.b;
    fast_res = '0;
    fast_ovf = 1'b0;
    unique case (op)
      OP_AND:  fast_res = bus.a & bus.b;
      OP_OR:   fast_res = bus.a | bus.b;
      OP_ADD: begin
        fast_res = sum;
        fast_ovf = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
      end
      OP_XOR:  fast_res = bus.a ^ bus.b;
      OP_ANDN: fast_res = bus.a & ~bus.b;
      OP_ORN:  fast_res = bus.a | ~bus.b;
      OP_SUB: begin
        fast_res = diff;
        fast_ovf = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
      end
      OP_SLTU: fast_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_NOR:  fast_res = ~(bus.a | bus.b);
      OP_SLL:  fast_res = bus.b << bus.shamt;
      OP_SRA:  fast_res = $unsigned($signed(bus.b) >>> bus.shamt);
      OP_SRL:  fast_res = bus.b >> bus.shamt;
      OP_SLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: fast_res = '0;
    endcase
  end

  // In MULU, hi:lo is the partial product with the multiplier in lo.
  // In DIVU, hi is the remainder and lo shifts the dividend out while the quotient shifts in.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[MSB]};
    div_ge    = (div_shift >= {1'b0, b_q});
    if (div_q) begin
      step_hi = div_ge ? WIDTH'(div_shift - {1'b0, b_q}) : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    aluout_d    = aluout_q;
    aluout_hi_d = aluout_hi_q;
    zero_d      = zero_q;
    sf_d        = sf_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (op == OP_MULU || op == OP_DIVU) begin
            state_d = S_BUSY;
            cnt_d   = '0;
            div_d   = (op == OP_DIVU);
            b_d     = bus.b;
            hi_d    = '0;
            lo_d    = bus.a;
          end else begin
            state_d     = S_DONE;
            aluout_d    = fast_res;
            aluout_hi_d = '0;
            zero_d      = (fast_res == '0);
            sf_d        = fast_res[MSB];
            ovf_d       = fast_ovf;
          end
        end
      end
      S_BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d     = S_DONE;
          aluout_d    = step_lo;
          aluout_hi_d = step_hi;
          zero_d      = (step_lo == '0);
          sf_d        = step_lo[MSB];
          ovf_d       = 1'b0;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= 1'b0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      aluout_q    <= '0;
      aluout_hi_q <= '0;
      zero_q      <= 1'b0;
      sf_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      b_q         <= b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      aluout_q    <= aluout_d;
      aluout_hi_q <= aluout_hi_d;
      zero_q      <= zero_d;
      sf_q        <= sf_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.aluout    = aluout_q;
  assign bus.aluout_hi = aluout_hi_q;
  assign bus.zero      = zero_q;
  assign bus.SF        = sf_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed test of alu_seq at WIDTH=32.
// The expected values are worked out by hand.
module tb_alu_seq;
  logic clk;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  alu_seq_if #(.WIDTH(32), .SHW(5)) bus ();

  alu_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // The operands are scrambled after accept to show that the block latched them.
  task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] sh, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.in_valid   = 1'b1;
    bus.alucontrol = op;
    bus.a          = av;
    bus.b          = bv;
    bus.shamt      = sh;
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.a          = $urandom;
    bus.b          = $urandom;
    bus.alucontrol = 4'($urandom);
    bus.shamt      = 5'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) begin
      total_cnt++;
      $display("FAIL timeout op=%b got out_valid=0 exp=1", op);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.alucontrol = '0; bus.shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
    total_cnt++; if ({bus.aluout, bus.aluout_hi} !== 64'h0) $display("FAIL rst_out got=%h exp=0", {bus.aluout, bus.aluout_hi}); else pass_cnt++;
    total_cnt++; if ({bus.zero, bus.SF, bus.ovf} !== 3'b000) $display("FAIL rst_flags got=%b exp=000", {bus.zero, bus.SF, bus.ovf}); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_ovf();
    int lat;
    run_op(4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd0, lat);
    total_cnt++; if (lat !== 1) $display("FAIL add_lat got=%0d exp=1", lat); else pass_cnt++;
    total_cnt++; if (bus.aluout !== 32'h80000000) $display("FAIL add_out got=%h exp=80000000", bus.aluout); else pass_cnt++;
    total_cnt++; if ({bus.zero, bus.SF, bus.ovf} !== 3'b011) $display("FAIL add_flags got=%b exp=011", {bus.zero, bus.SF, bus.ovf}); else pass_cnt++;
    total_cnt++; if (bus.aluout_hi !== 32'h0) $display("FAIL add_hi got=%h exp=0", bus.aluout_hi); else pass_cnt++;
  endtask

  task automatic test_logic();
    int lat;
    run_op(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, lat);
    total_cnt++; if (bus.aluout !== 32'hF000F000) $display("FAIL and_out got=%h exp=F000F000", bus.aluout); else pass_cnt++;
    run_op(4'b1000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, lat);
    total_cnt++; if (bus.aluout !== 32'h000F000F) $display("FAIL nor_out got=%h exp=000F000F", bus.aluout); else pass_cnt++;
    run_op(4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, lat);
    total_cnt++; if (bus.aluout !== 32'h00F000F0) $display("FAIL andn_out got=%h exp=00F000F0", bus.aluout); else pass_cnt++;
    run_op(4'b0101, 32'h00000000, 32'hFFFF0000, 5'd0, lat);
    total_cnt++; if (bus.aluout !== 32'h0000FFFF) $display("FAIL orn_out got=%h exp=0000FFFF", bus.aluout); else pass_cnt++;
    run_op(4'b0011, 32'hAAAA5555, 32'hFFFF0000, 5'd0, lat);
    total_cnt++; if (bus.aluout !== 32'h55555555) $display("FAIL xor_out got=%h exp=55555555", bus.aluout); else pass_cnt++;
  endtask

  task automatic test_shifts();
    int lat;
    run_op(4'b1011, 32'h12345678, 32'hF0000000, 5'd4, lat);
    total_cnt++; if (lat !== 1) $display("FAIL sra_lat got=%0d exp=1", lat); else pass_cnt++;
    total_cnt++; if (bus.aluout !== 32'hFF000000) $display("FAIL sra_out got=%h exp=FF000000", bus.aluout); else pass_cnt++;
    run_op(4'b1100, 32'h12345678, 32'hF0000000, 5'd4, lat);
    total_cnt++; if (bus.aluout !== 32'h0F000000) $display("FAIL srl_out got=%h exp=0F000000", bus.aluout); else pass_cnt++;
    run_op(4'b1010, 32'h0, 32'h00000001, 5'd31, lat);
    total_cnt++; if ({bus.aluout, bus.SF} !== {32'h80000000, 1'b1}) $display("FAIL sll_out got=%h exp=80000000 SF=1", bus.aluout); else pass_cnt++;
  endtask

  task automatic test_compare();
    int lat;
    run_op(4'b1101, 32'hFFFFFFFF, 32'h00000001, 5'd0, lat);
    total_cnt++; if (bus.aluout !== 32'h1) $display("FAIL slt_out got=%h exp=1", bus.aluout); else pass_cnt++;
    run_op(4'b0111, 32'hFFFFFFFF, 32'h00000001, 5'd0, lat);
    total_cnt++; if ({bus.aluout, bus.zero} !== {32'h0, 1'b1}) $display("FAIL sltu_out got=%h zero=%b exp=0 zero=1", bus.aluout, bus.zero); else pass_cnt++;
    run_op(4'b1111, 32'h12345678, 32'h9ABCDEF0, 5'd3, lat);
    total_cnt++; if ({lat, bus.aluout, bus.zero} !== {32'd1, 32'h0, 1'b1}) $display("FAIL rsvd got lat=%0d out=%h zero=%b exp lat=1 out=0 zero=1", lat, bus.aluout, bus.zero); else pass_cnt++;
  endtask

  task automatic test_mulu();
    int lat;
    run_op(4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, lat);
    total_cnt++; if (lat !== 33) $display("FAIL mulu_lat got=%0d exp=33", lat); else pass_cnt++;
    total_cnt++; if (bus.aluout_hi !== 32'hFFFFFFFE) $display("FAIL mulu_hi got=%h exp=FFFFFFFE", bus.aluout_hi); else pass_cnt++;
    total_cnt++; if (bus.aluout !== 32'h00000001) $display("FAIL mulu_lo got=%h exp=00000001", bus.aluout); else pass_cnt++;
    run_op(4'b1001, 32'h00010003, 32'h00020005, 5'd0, lat);
    total_cnt++; if ({bus.aluout_hi, bus.aluout} !== 64'h00000002_000B000F) $display("FAIL mulu2 got=%h exp=00000002000B000F", {bus.aluout_hi, bus.aluout}); else pass_cnt++;
  endtask

  task automatic test_divu();
    int lat;
    run_op(4'b1110, 32'h00000064, 32'h00000007, 5'd0, lat);
    total_cnt++; if (lat !== 33) $display("FAIL divu_lat got=%0d exp=33", lat); else pass_cnt++;
    total_cnt++; if (bus.aluout !== 32'h0000000E) $display("FAIL divu_q got=%h exp=0000000E", bus.aluout); else pass_cnt++;
    total_cnt++; if (bus.aluout_hi !== 32'h00000002) $display("FAIL divu_r got=%h exp=00000002", bus.aluout_hi); else pass_cnt++;
    run_op(4'b1110, 32'h00000005, 32'h00000000, 5'd0, lat);
    total_cnt++; if (lat !== 33) $display("FAIL div0_lat got=%0d exp=33", lat); else pass_cnt++;
    total_cnt++; if ({bus.aluout, bus.aluout_hi} !== {32'hFFFFFFFF, 32'h5}) $display("FAIL div0 got=%h/%h exp=FFFFFFFF/00000005", bus.aluout, bus.aluout_hi); else pass_cnt++;
    run_op(4'b1110, 32'hFFFFFFFF, 32'h80000000, 5'd0, lat);
    total_cnt++; if ({bus.aluout, bus.aluout_hi} !== {32'h1, 32'h7FFFFFFF}) $display("FAIL divbig got=%h/%h exp=00000001/7FFFFFFF", bus.aluout, bus.aluout_hi); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(4'b0110, 32'h80000000, 32'h00000001, 5'd0, lat);
    total_cnt++; if ({bus.aluout, bus.ovf, bus.SF} !== {32'h7FFFFFFF, 1'b1, 1'b0}) $display("FAIL sub_ovf got=%h ovf=%b SF=%b exp=7FFFFFFF ovf=1 SF=0", bus.aluout, bus.ovf, bus.SF); else pass_cnt++;
    run_op(4'b0010, 32'hFFFFFFFF, 32'h00000001, 5'd0, lat);
    total_cnt++; if ({bus.aluout, bus.zero, bus.ovf} !== {32'h0, 1'b1, 1'b0}) $display("FAIL add_wrap got=%h zero=%b ovf=%b exp=0 zero=1 ovf=0", bus.aluout, bus.zero, bus.ovf); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int lat;
    bus.out_ready = 1'b0;
    run_op(4'b0110, 32'h5, 32'h5, 5'd0, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.alucontrol = 4'b0010; bus.a = 32'h1; bus.b = 32'h1;
      total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, bus.out_valid); else pass_cnt++;
      total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); else pass_cnt++;
      total_cnt++; if ({bus.aluout, bus.zero} !== {32'h0, 1'b1}) $display("FAIL bp_hold cyc=%0d got=%h zero=%b exp=0 zero=1", i, bus.aluout, bus.zero); else pass_cnt++;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++; if ({bus.in_ready, bus.out_valid} !== 2'b10) $display("FAIL bp_release got ready/valid=%b exp=10", {bus.in_ready, bus.out_valid}); else pass_cnt++;
    total_cnt++; if ({bus.aluout, bus.zero} !== {32'h0, 1'b1}) $display("FAIL bp_idle_hold got=%h zero=%b exp=0 zero=1", bus.aluout, bus.zero); else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL bp_no_capture got out_valid=%b exp=0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alucontrol = 4'b1001;
    bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++; if ({bus.in_ready, bus.out_valid} !== 2'b10) $display("FAIL midrst_hs got ready/valid=%b exp=10", {bus.in_ready, bus.out_valid}); else pass_cnt++;
    total_cnt++; if ({bus.aluout, bus.aluout_hi, bus.zero, bus.SF, bus.ovf} !== 67'h0) $display("FAIL midrst_out got=%h/%h flags=%b exp=0", bus.aluout, bus.aluout_hi, {bus.zero, bus.SF, bus.ovf}); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    run_op(4'b0010, 32'h2, 32'h3, 5'd0, lat);
    total_cnt++; if ({lat, bus.aluout, bus.aluout_hi} !== {32'd1, 32'h5, 32'h0}) $display("FAIL midrst_add got lat=%0d out=%h hi=%h exp lat=1 out=5 hi=0", lat, bus.aluout, bus.aluout_hi); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_logic();
    test_shifts();
    test_compare();
    test_mulu();
    test_divu();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
